// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states and requester ids.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle. The slave view belongs to the arbiter; the master view belongs to its environment.
interface mem_arbiter_if #(parameter int BITSIZE = 32);
  logic [BITSIZE-1:0] IF_addr_i;
  logic               IF_read_i;
  logic               IF_flush_i;
  logic [BITSIZE-1:0] IF_data_o;
  logic               IF_valid_o;

  logic [BITSIZE-1:0] DM_addr_i;
  logic [BITSIZE-1:0] DM_data_i;
  logic               DM_read_i;
  logic               DM_write_i;
  logic [3:0]         DM_be_i;
  logic [BITSIZE-1:0] DM_data_o;
  logic               DM_valid_o;

  logic [BITSIZE-1:0] MEM_addr_o;
  logic [BITSIZE-1:0] MEM_data_o;
  logic               MEM_read_o;
  logic               MEM_write_o;
  logic [3:0]         MEM_be_o;
  logic [BITSIZE-1:0] MEM_data_i;
  logic               MEM_valid_i;

  modport slave (
    input  IF_addr_i, IF_read_i, IF_flush_i, DM_addr_i, DM_data_i, DM_read_i,
           DM_write_i, DM_be_i, MEM_data_i, MEM_valid_i,
    output IF_data_o, IF_valid_o, DM_data_o, DM_valid_o,
           MEM_addr_o, MEM_data_o, MEM_read_o, MEM_write_o, MEM_be_o
  );

  modport master (
    output IF_addr_i, IF_read_i, IF_flush_i, DM_addr_i, DM_data_i, DM_read_i,
           DM_write_i, DM_be_i, MEM_data_i, MEM_valid_i,
    input  IF_data_o, IF_valid_o, DM_data_o, DM_valid_o,
           MEM_addr_o, MEM_data_o, MEM_read_o, MEM_write_o, MEM_be_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port, round-robin on ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input logic          clk,
  input logic          rstn_i,
  mem_arbiter_if.slave bus
);

  state_t             state_q, state_d;
  req_id_t            last_q, last_d;
  logic               abort_q, abort_d;
  logic               wr_q, wr_d;
  logic [BITSIZE-1:0] addr_q, addr_d;
  logic [BITSIZE-1:0] wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;

  logic if_req, dm_req, grant_if, grant_dm, busy;
  logic if_vld, dm_vld;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      last_q  <= REQ_DM;
      abort_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      abort_q <= abort_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    abort_d  = abort_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if_vld   = 1'b0;
    dm_vld   = 1'b0;
    // A flush in the same cycle as a fetch request withdraws that request.
    if_req   = bus.IF_read_i && !bus.IF_flush_i;
    dm_req   = bus.DM_read_i || bus.DM_write_i;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (if_req && dm_req) begin
          grant_if = (last_q == REQ_DM);
          grant_dm = !grant_if;
        end else begin
          grant_if = if_req;
          grant_dm = dm_req;
        end
        if (grant_if) begin
          state_d = SERVE_IF;
          last_d  = REQ_IF;
          wr_d    = 1'b0;
          addr_d  = bus.IF_addr_i;
          wdata_d = '0;
          be_d    = '0;
        end else if (grant_dm) begin
          state_d = SERVE_DM;
          last_d  = REQ_DM;
          wr_d    = bus.DM_write_i;
          addr_d  = bus.DM_addr_i;
          wdata_d = bus.DM_data_i;
          be_d    = bus.DM_be_i;
        end
      end
      SERVE_IF: begin
        if (bus.IF_flush_i) abort_d = 1'b1;
        if (bus.MEM_valid_i) begin
          // An aborted fetch still drains the memory but returns nothing.
          if_vld  = !abort_q && !bus.IF_flush_i;
          abort_d = 1'b0;
          state_d = IDLE;
        end
      end
      SERVE_DM: begin
        if (bus.MEM_valid_i) begin
          dm_vld  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  assign bus.MEM_addr_o  = busy ? addr_q  : '0;
  assign bus.MEM_data_o  = busy ? wdata_q : '0;
  assign bus.MEM_be_o    = busy ? be_q    : '0;
  assign bus.MEM_read_o  = busy && !wr_q;
  assign bus.MEM_write_o = busy &&  wr_q;

  assign bus.IF_valid_o  = if_vld;
  assign bus.DM_valid_o  = dm_vld;
  assign bus.IF_data_o   = if_vld ? bus.MEM_data_i : '0;
  assign bus.DM_data_o   = dm_vld ? bus.MEM_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard checked on the falling edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.BITSIZE(32)) bus ();
  mem_arbiter #(.BITSIZE(32)) dut (.clk(clk), .rstn_i(rstn_i), .bus(bus));

  typedef struct { bit dm; logic [31:0] data; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dm(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    bus.DM_read_i  = rd;
    bus.DM_write_i = wr;
    bus.DM_addr_i  = addr;
    bus.DM_data_i  = data;
    bus.DM_be_i    = be;
  endtask

  // Waits for the grant, checks the memory port each serve cycle while the
  // requester inputs are scrambled, responds on cycle lat, then drops the request.
  task automatic serve(input string tag, input bit is_dm, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] rdata,
                       input int lat, input int flush_at);
    int n;
    logic [69:0] exp_mem;
    exp_t e;
    n = 0;
    while (!(bus.MEM_read_o || bus.MEM_write_o) && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_grant_delay"}, n, 1);
    exp_mem = {addr, wdata, be, !wr, wr};
    for (int c = 1; c <= lat; c++) begin
      chk({tag, "_mem"}, {bus.MEM_addr_o, bus.MEM_data_o, bus.MEM_be_o,
                          bus.MEM_read_o, bus.MEM_write_o}, exp_mem);
      bus.IF_addr_i  = $urandom;
      bus.DM_addr_i  = $urandom;
      bus.DM_data_i  = $urandom;
      bus.DM_be_i    = 4'($urandom);
      bus.IF_flush_i = (c == flush_at);
      if (c == lat) begin
        bus.MEM_valid_i = 1'b1;
        bus.MEM_data_i  = rdata;
        if (flush_at == 0) begin
          e.dm = is_dm;
          e.data = rdata;
          sb.push_back(e);
        end
      end
      step();
    end
    bus.MEM_valid_i = 1'b0;
    bus.MEM_data_i  = '0;
    bus.IF_flush_i  = 1'b0;
    if (is_dm) begin
      bus.DM_read_i  = 1'b0;
      bus.DM_write_i = 1'b0;
    end else begin
      bus.IF_read_i = 1'b0;
    end
    chk({tag, "_back_idle"}, {bus.MEM_read_o, bus.MEM_write_o}, 2'b00);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("valid_exclusive", bus.IF_valid_o & bus.DM_valid_o, 1'b0);
    if (bus.IF_valid_o || bus.DM_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {bus.IF_valid_o, bus.DM_valid_o}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("sb_who", {bus.IF_valid_o, bus.DM_valid_o}, e.dm ? 2'b01 : 2'b10);
        chk("sb_data", e.dm ? bus.DM_data_o : bus.IF_data_o, e.data);
      end
    end else begin
      chk("idle_data_zero", {bus.IF_data_o, bus.DM_data_o}, 64'h0);
    end
  end

  initial begin
    bus.IF_addr_i = '0; bus.IF_read_i = 1'b0; bus.IF_flush_i = 1'b0;
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.MEM_data_i = '0; bus.MEM_valid_i = 1'b0;

    // Reset state, with a stray request pending
    bus.IF_read_i = 1'b1;
    repeat (2) step();
    chk("rst_mem", {bus.MEM_addr_o, bus.MEM_data_o, bus.MEM_be_o,
                    bus.MEM_read_o, bus.MEM_write_o}, 70'h0);
    chk("rst_valid", {bus.IF_valid_o, bus.DM_valid_o}, 2'b00);
    bus.IF_read_i = 1'b0;
    rstn_i = 1'b1;
    step();

    // Single fetch, three-cycle memory latency
    bus.IF_addr_i = 32'h100;
    bus.IF_read_i = 1'b1;
    chk("if_not_same_cycle", bus.MEM_read_o, 1'b0);
    serve("if_read", 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 3, 0);

    // Tie after a fresh reset: IF first, then alternation
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
    bus.IF_addr_i = 32'h400;
    bus.IF_read_i = 1'b1;
    set_dm(1'b1, 1'b0, 32'h2000, 32'h0, 4'hF);
    serve("tie1_if", 1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 32'h11111111, 2, 0);
    set_dm(1'b1, 1'b0, 32'h2000, 32'h0, 4'hF);
    bus.IF_addr_i = 32'h440;
    bus.IF_read_i = 1'b1;
    serve("tie2_dm", 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 32'h22222222, 2, 0);
    bus.IF_addr_i = 32'h440;
    serve("tie2_if", 1'b0, 1'b0, 32'h440, 32'h0, 4'h0, 32'h33333333, 1, 0);

    // Store with byte enables
    set_dm(1'b0, 1'b1, 32'h3000, 32'h12345678, 4'b0011);
    serve("store", 1'b1, 1'b1, 32'h3000, 32'h12345678, 4'b0011, 32'hCAFE0000, 4, 0);

    // Flush in IDLE blocks the fetch grant that cycle
    bus.IF_addr_i  = 32'h480;
    bus.IF_read_i  = 1'b1;
    bus.IF_flush_i = 1'b1;
    step();
    chk("idle_flush_blocks", bus.MEM_read_o, 1'b0);
    bus.IF_flush_i = 1'b0;
    serve("after_idle_flush", 1'b0, 1'b0, 32'h480, 32'h0, 4'h0, 32'h44444444, 1, 0);

    // Flush during SERVE_IF: memory completes, no fetch data returned
    bus.IF_addr_i = 32'h500;
    bus.IF_read_i = 1'b1;
    serve("flushed_if", 1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 32'h55555555, 3, 1);
    bus.IF_addr_i = 32'h600;
    bus.IF_read_i = 1'b1;
    serve("refetch", 1'b0, 1'b0, 32'h600, 32'h0, 4'h0, 32'h66666666, 2, 0);

    // Stray response in IDLE is ignored
    bus.MEM_valid_i = 1'b1;
    bus.MEM_data_i  = 32'hBAD0BAD0;
    #1;
    chk("idle_resp_ignored", {bus.IF_valid_o, bus.DM_valid_o}, 2'b00);
    step();
    bus.MEM_valid_i = 1'b0;
    bus.MEM_data_i  = '0;

    // Reset in the middle of a load
    set_dm(1'b1, 1'b0, 32'h7000, 32'h0, 4'hF);
    step();
    chk("rst_mid_serving", {bus.MEM_addr_o, bus.MEM_read_o}, {32'h7000, 1'b1});
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_mem", {bus.MEM_addr_o, bus.MEM_data_o, bus.MEM_be_o,
                        bus.MEM_read_o, bus.MEM_write_o}, 70'h0);
    chk("rst_mid_valid", {bus.IF_valid_o, bus.DM_valid_o}, 2'b00);
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.MEM_valid_i = 1'b1;
    bus.MEM_data_i  = 32'h77777777;
    step();
    rstn_i = 1'b1;
    #1;
    chk("late_resp_ignored", {bus.IF_valid_o, bus.DM_valid_o, bus.MEM_read_o}, 3'b000);
    step();
    bus.MEM_valid_i = 1'b0;
    step();

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
